maxnet_controller: RTL

- Sequencing FSM that drives the MaxNet datapath's load strobes (ldI, ldInit, ldM, ldRes, ldA).
- Accepts a new 4-input problem through a start/ready handshake and runs iterations until the datapath reports exactly three zero activations (dp_done), or until an iteration limit is reached.
- Captures the datapath's max value and returns it through a valid/ack result handshake.
- Sits directly upstream of, and in control of, the datapath.

---
 rtl/maxnet_controller.sv | 132 +++++++++++++
 1 files changed

// File: rtl/maxnet_controller.sv
// Sequencing FSM for the MaxNet datapath: runs load-strobe iterations until the
// datapath reports convergence or the iteration limit, then presents the winner.
module maxnet_controller #(
  parameter int MUL_CYCLES = 1,
  parameter int ACC_CYCLES = 1,
  parameter int MAX_ITER   = 32,
  parameter int ITER_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              in_ready,
  output logic              ldI,
  output logic              ldInit,
  output logic              ldM,
  output logic              ldRes,
  output logic              ldA,
  input  logic              dp_done,
  input  logic [31:0]       dp_max,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ack,
  output logic [31:0]       res_max,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_ACC   = 3'd4;
  localparam logic [2:0] S_UPD   = 3'd5;
  localparam logic [2:0] S_HOLD  = 3'd6;

  localparam logic [3:0]        MUL_LAST = 4'(MUL_CYCLES - 1);
  localparam logic [3:0]        ACC_LAST = 4'(ACC_CYCLES - 1);
  localparam logic [ITER_W-1:0] ITER_LIM = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ITER_SAT = {ITER_W{1'b1}};

  logic [2:0]        state_q, state_d;
  logic [3:0]        sub_q, sub_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [31:0]       max_q, max_d;
  logic              tmo_q, tmo_d;

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    iter_d  = iter_q;
    max_d   = max_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          iter_d  = '0;
          tmo_d   = 1'b0;
          state_d = S_INIT;
        end
      end
      S_INIT: state_d = S_CHECK;
      S_CHECK: begin
        // convergence wins over the limit when both hold on the same check
        if (dp_done) begin
          max_d   = dp_max;
          state_d = S_HOLD;
        end else if (iter_q == ITER_LIM) begin
          max_d   = '0;
          tmo_d   = 1'b1;
          state_d = S_HOLD;
        end else begin
          sub_d   = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (sub_q == MUL_LAST) begin
          sub_d   = '0;
          state_d = S_ACC;
        end else begin
          sub_d = sub_q + 4'd1;
        end
      end
      S_ACC: begin
        if (sub_q == ACC_LAST) begin
          sub_d   = '0;
          state_d = S_UPD;
        end else begin
          sub_d = sub_q + 4'd1;
        end
      end
      S_UPD: begin
        if (iter_q != ITER_SAT) iter_d = iter_q + ITER_W'(1);
        state_d = S_CHECK;
      end
      S_HOLD: begin
        if (res_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sub_q   <= '0;
      iter_q  <= '0;
      max_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      iter_q  <= iter_d;
      max_q   <= max_d;
      tmo_q   <= tmo_d;
    end
  end

  // strobes decode the registered state only; start is the lone Mealy term
  assign in_ready   = (state_q == S_IDLE);
  assign ldI        = in_ready & start;
  assign ldInit     = (state_q == S_INIT);
  assign ldM        = (state_q == S_MUL);
  assign ldRes      = (state_q == S_ACC);
  assign ldA        = (state_q == S_UPD);
  assign busy       = ~in_ready;
  assign res_valid  = (state_q == S_HOLD);
  assign res_max    = max_q;
  assign timeout    = tmo_q;
  assign iter_count = iter_q;

endmodule
